// File: rtl/comma_aligner.sv
// comma_aligner: serial-to-symbol front end of the 8b10b receive path.
// The block shifts in the recovered serial stream and hunts for a K28.5 comma.
// It locks symbol alignment once LOCK_CNT commas land on the same phase.
// While locked it emits one framed 10-bit symbol (bit a at [9]) per ten accepted bits.
// Optional feature: define COMMA_ALIGN_SLIP_CNT_EN to add slip_cnt_o, a count of
// lock losses that saturates at 255.
module comma_aligner #(
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned LOSS_CNT = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       sdata_i,
  input  logic       sdata_vld_i,
  output logic [9:0] data_o,
  output logic       data_vld_o,
  output logic       comma_o,
  output logic       lock_o
`ifdef COMMA_ALIGN_SLIP_CNT_EN
  ,
  output logic [7:0] slip_cnt_o
`endif
);

  localparam logic [9:0]  K28_5_RDN = 10'b0011111010;
  localparam logic [9:0]  K28_5_RDP = 10'b1100000101;
  localparam int unsigned CW        = $clog2(LOCK_CNT + 1);
  localparam int unsigned MW        = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [8:0]      sh_q, sh_d;
  logic [3:0]      ph_q, ph_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [MW-1:0]   miss_q, miss_d;
  logic [9:0]      data_q, data_d;
  logic            vld_q, vld_d;
  logic            comma_q, comma_d;
  logic            lock_q, lock_d;
`ifdef COMMA_ALIGN_SLIP_CNT_EN
  logic [7:0]      slip_q, slip_d;
`endif

  // The 10-bit window always includes the bit being offered this cycle.
  logic [9:0] win;
  logic       comma_hit;
  logic       boundary;

  assign win       = {sh_q, sdata_i};
  assign comma_hit = (win == K28_5_RDN) || (win == K28_5_RDP);
  assign boundary  = (ph_q == 4'd9);

  // Alignment FSM, phase tracking and symbol framing for one accepted bit.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    miss_d  = miss_q;
    data_d  = data_q;
    vld_d   = 1'b0;
    comma_d = comma_q;

    if (sdata_vld_i) begin
      sh_d = win[8:0];
      ph_d = boundary ? 4'd0 : (ph_q + 4'd1);

      unique case (state_q)
        HUNT: begin
          // Any comma, at any phase, defines a candidate alignment.
          if (comma_hit) begin
            ph_d = 4'd0;
            if (LOCK_CNT == 1) begin
              state_d = LOCKED;
              cnt_d   = '0;
            end else begin
              state_d = VERIFY;
              cnt_d   = CW'(1);
            end
          end
        end

        VERIFY: begin
          if (comma_hit) begin
            if (boundary) begin
              if (cnt_q == CW'(LOCK_CNT - 1)) begin
                state_d = LOCKED;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end else begin
              // A comma at a new phase restarts verification there.
              ph_d  = 4'd0;
              cnt_d = CW'(1);
            end
          end
        end

        LOCKED: begin
          if (boundary) begin
            // Boundary wins even when the window is a comma: never a miss.
            data_d  = win;
            vld_d   = 1'b1;
            comma_d = comma_hit;
            if (comma_hit) begin
              miss_d = '0;
            end
          end else if (comma_hit) begin
            // Misaligned commas do not realign while locked; enough of them drop lock.
            if (miss_q == MW'(LOSS_CNT - 1)) begin
              state_d = HUNT;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end
        end

        default: begin
          state_d = HUNT;
        end
      endcase
    end

    lock_d = (state_d == LOCKED);
  end

`ifdef COMMA_ALIGN_SLIP_CNT_EN
  // Count each LOCKED to HUNT drop, holding at 255 until reset.
  always_comb begin
    slip_d = slip_q;
    if ((state_q == LOCKED) && (state_d == HUNT) && (slip_q != 8'hFF)) begin
      slip_d = slip_q + 8'd1;
    end
  end

  assign slip_cnt_o = slip_q;
`endif

  // State and output registers; reset discards any partial symbol.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= HUNT;
      sh_q    <= '0;
      ph_q    <= '0;
      cnt_q   <= '0;
      miss_q  <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      comma_q <= 1'b0;
      lock_q  <= 1'b0;
`ifdef COMMA_ALIGN_SLIP_CNT_EN
      slip_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      miss_q  <= miss_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      comma_q <= comma_d;
      lock_q  <= lock_d;
`ifdef COMMA_ALIGN_SLIP_CNT_EN
      slip_q  <= slip_d;
`endif
    end
  end

  assign data_o     = data_q;
  assign data_vld_o = vld_q;
  assign comma_o    = comma_q;
  assign lock_o     = lock_q;

endmodule
